// File: rtl/fabric_port_pkg.sv
// rtl/fabric_port_pkg.sv - shared types and flit field helpers for the fabric input port
package fabric_port_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Control field occupies the top CTRL_W bits of a flit, vc sits directly above the payload.
    localparam int CTRL_W    = 3;
    localparam int VALID_BIT = 2;
    localparam int HEAD_BIT  = 1;
    localparam int TAIL_BIT  = 0;
    localparam int VC_LSB    = 0;

    function automatic logic [CTRL_W-1:0] pack_ctrl(input logic head, input logic tail);
        logic [CTRL_W-1:0] ctrl;
        ctrl            = '0;
        ctrl[VALID_BIT] = 1'b1;
        ctrl[HEAD_BIT]  = head;
        ctrl[TAIL_BIT]  = tail;
        return ctrl;
    endfunction

endpackage

// File: rtl/fabric_port_in_mvc_credit_counter.sv
// rtl/fabric_port_in_mvc_credit_counter.sv - per-VC credit counter with sticky overflow flag
module credit_counter #(
    parameter int DEPTH = 10,
    parameter int WIDTH = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             avail,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] FULL = WIDTH'(DEPTH);

    logic [WIDTH-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (dec && !inc) begin
            count_d = count_q - 1'b1;
        end else if (inc && !dec) begin
            if (count_q == FULL) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= FULL;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign avail    = (count_q != '0);
    assign overflow = overflow_q;

endmodule

// File: rtl/fabric_port_in_mvc.sv
// rtl/fabric_port_in_mvc.sv - multi-VC fabric input port: packet serializer gated by per-VC credits
module fabric_port_in_mvc
    import fabric_port_pkg::*;
#(
    parameter int WIDTH_NOC        = 36,
    parameter int N                = 16,
    parameter int NUM_VC           = 2,
    parameter int DEPTH_PER_VC     = 10,
    parameter int FLITS_MAX        = 4,
    parameter int VC_ADDRESS_WIDTH = $clog2(NUM_VC),
    parameter int WIDTH_DATA       = WIDTH_NOC - 3 - VC_ADDRESS_WIDTH,
    parameter int WIDTH_RTL        = FLITS_MAX * WIDTH_DATA,
    parameter int LEN_WIDTH        = $clog2(FLITS_MAX + 1),
    parameter int CREDIT_WIDTH     = $clog2(DEPTH_PER_VC + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH_RTL-1:0]        rtl_packet_in,
    input  logic [LEN_WIDTH-1:0]        rtl_len_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] rtl_vc_in,
    input  logic                        rtl_valid_in,
    output logic                        rtl_ready_out,
    output logic [WIDTH_NOC-1:0]        noc_flit_out,
    input  logic [NUM_VC-1:0]           noc_credits_in,
    output logic                        credit_err_out
);

    if (NUM_VC < 2) begin : g_bad_vc
        $error("fabric_port_in_mvc: NUM_VC must be at least 2");
    end
    if (FLITS_MAX < 1) begin : g_bad_flits
        $error("fabric_port_in_mvc: FLITS_MAX must be at least 1");
    end
    if (N < 1) begin : g_bad_n
        $error("fabric_port_in_mvc: N must be at least 1");
    end

    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
        if (len == '0) return LEN_WIDTH'(1);
        if (len > LEN_WIDTH'(FLITS_MAX)) return LEN_WIDTH'(FLITS_MAX);
        return len;
    endfunction

    state_t                      state_q, state_d;
    logic [WIDTH_RTL-1:0]        pkt_q, pkt_d;
    logic [VC_ADDRESS_WIDTH-1:0] vc_q, vc_d;
    logic [LEN_WIDTH-1:0]        len_q, len_d;
    logic [LEN_WIDTH-1:0]        idx_q, idx_d;
    logic [WIDTH_NOC-1:0]        flit_q, flit_d;

    logic [NUM_VC-1:0]                    avail_vec;
    logic [NUM_VC-1:0]                    dec_vec;
    logic [NUM_VC-1:0]                    overflow_vec;
    logic [NUM_VC-1:0][CREDIT_WIDTH-1:0]  credit_cnt;
    logic                                 unused_credit_cnt;
    logic                                 fire;
    logic                                 last_flit;
    logic                                 accept;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_credit
        credit_counter #(
            .DEPTH (DEPTH_PER_VC),
            .WIDTH (CREDIT_WIDTH)
        ) u_credit (
            .clk      (clk),
            .rst      (rst),
            .inc      (noc_credits_in[v]),
            .dec      (dec_vec[v]),
            .count    (credit_cnt[v]),
            .avail    (avail_vec[v]),
            .overflow (overflow_vec[v])
        );
    end

    // Raw counts are kept visible for debug; the datapath only needs avail.
    assign unused_credit_cnt = ^credit_cnt;

    // Fire decision uses the registered count, so a same-cycle return cannot rescue a zero credit.
    assign fire          = (state_q == SEND) && avail_vec[vc_q];
    assign last_flit     = fire && (idx_q == len_q - 1'b1);
    assign rtl_ready_out = (state_q == IDLE) || last_flit;
    assign accept        = rtl_valid_in && rtl_ready_out;

    always_comb begin
        dec_vec = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            dec_vec[v] = fire && (vc_q == VC_ADDRESS_WIDTH'(v));
        end
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        vc_d    = vc_q;
        len_d   = len_q;
        idx_d   = idx_q;
        flit_d  = '0;

        if (fire) begin
            flit_d[WIDTH_DATA-1:0]                         = pkt_q[idx_q*WIDTH_DATA +: WIDTH_DATA];
            flit_d[WIDTH_DATA+VC_LSB +: VC_ADDRESS_WIDTH]  = vc_q;
            flit_d[WIDTH_NOC-1 -: CTRL_W]                  = pack_ctrl(idx_q == '0, last_flit);
            idx_d = idx_q + 1'b1;
        end

        if (accept) begin
            state_d = SEND;
            pkt_d   = rtl_packet_in;
            vc_d    = rtl_vc_in;
            len_d   = clamp_len(rtl_len_in);
            idx_d   = '0;
        end else if (last_flit) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pkt_q   <= '0;
            vc_q    <= '0;
            len_q   <= LEN_WIDTH'(1);
            idx_q   <= '0;
            flit_q  <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            vc_q    <= vc_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            flit_q  <= flit_d;
        end
    end

    assign noc_flit_out   = flit_q;
    assign credit_err_out = |overflow_vec;

endmodule

// File: tb/tb_fabric_port_in_mvc.sv
// tb/tb_fabric_port_in_mvc.sv - randomized and directed bench with a packet-queue reference model
module tb_fabric_port_in_mvc;

    localparam int WN  = 36;
    localparam int NV  = 2;
    localparam int DEP = 10;
    localparam int FM  = 4;
    localparam int WD  = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [127:0]   pkt;
    logic [2:0]     len;
    logic           vc;
    logic           valid;
    logic           ready;
    logic [WN-1:0]  flit;
    logic [NV-1:0]  cred;
    logic           err;

    fabric_port_in_mvc #(
        .WIDTH_NOC    (WN),
        .N            (16),
        .NUM_VC       (NV),
        .DEPTH_PER_VC (DEP),
        .FLITS_MAX    (FM)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rtl_packet_in  (pkt),
        .rtl_len_in     (len),
        .rtl_vc_in      (vc),
        .rtl_valid_in   (valid),
        .rtl_ready_out  (ready),
        .noc_flit_out   (flit),
        .noc_credits_in (cred),
        .credit_err_out (err)
    );

    always #5 clk = ~clk;

    int            vectors = 0;
    int            miscompares = 0;
    int            m_cred[NV];
    bit            m_err;
    int            m_vc;
    logic [WN-1:0] m_pend[$];
    logic [WN-1:0] obs[$];
    bit            acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: predict from packet queue + credit table, then compare after the edge.
    task automatic step(output bit accepted);
        bit            busy, fire, last, rdy, dec;
        logic [WN-1:0] ef;
        logic [WN-1:0] f;
        int            l;
        #1;
        busy = (m_pend.size() != 0);
        fire = busy && (m_cred[m_vc] > 0);
        last = fire && (m_pend.size() == 1);
        rdy  = !busy || last;
        accepted = 1'b0;
        ef = '0;
        if (rst) begin
            m_pend.delete();
            for (int v = 0; v < NV; v++) m_cred[v] = DEP;
            m_err = 1'b0;
        end else begin
            chk("ready", 64'(ready), 64'(rdy));
            if (fire) ef = m_pend.pop_front();
            for (int v = 0; v < NV; v++) begin
                dec = fire && (v == m_vc);
                if (cred[v] && !dec && m_cred[v] == DEP) m_err = 1'b1;
                else m_cred[v] = m_cred[v] - int'(dec) + int'(cred[v]);
            end
            if (valid && rdy) begin
                accepted = 1'b1;
                l = (len == 0) ? 1 : ((int'(len) > FM) ? FM : int'(len));
                m_vc = int'(vc);
                for (int k = 0; k < l; k++) begin
                    f = {1'b1, k == 0, k == l - 1, vc, pkt[k*WD +: WD]};
                    m_pend.push_back(f);
                end
            end
        end
        @(posedge clk);
        #1;
        chk("flit", 64'(flit), 64'(ef));
        chk("credit_err", 64'(err), 64'(m_err));
        if (flit[WN-1]) obs.push_back(flit);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic send_pkt(input logic [127:0] p, input logic [2:0] l, input logic c);
        bit a;
        int n;
        pkt = p; len = l; vc = c; valid = 1'b1;
        n = 0;
        do begin
            step(a);
            n++;
        end while (!a && n < 200);
        if (!a) chk("accept_timeout", 64'(0), 64'(1));
        valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; cred = '0;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        pkt = '0; len = '0; vc = 1'b0; valid = 1'b0; cred = '0; rst = 1'b1;
        m_vc = 0; m_err = 1'b0;
        for (int v = 0; v < NV; v++) m_cred[v] = DEP;
        idle(2);
        rst = 1'b0;
        chk("reset_flit", 64'(flit), 64'(0));
        chk("reset_err", 64'(err), 64'(0));
        chk("reset_ready", 64'(ready), 64'(1));

        // 4-flit packet on VC1
        obs.delete();
        send_pkt({32'hD, 32'hC, 32'hB, 32'hA}, 3'd4, 1'b1);
        idle(5);
        chk("t1_count", 64'(obs.size()), 64'(4));
        if (obs.size() == 4) begin
            chk("t1_head", 64'(obs[0]), 64'(36'hD0000000A));
            chk("t1_body1", 64'(obs[1]), 64'(36'h90000000B));
            chk("t1_body2", 64'(obs[2]), 64'(36'h90000000C));
            chk("t1_tail", 64'(obs[3]), 64'(36'hB0000000D));
        end
        chk("t1_credit1", 64'(dut.credit_cnt[1]), 64'(6));
        chk("t1_model_credit1", 64'(m_cred[1]), 64'(6));

        // len=1 then len=0 packets
        obs.delete();
        send_pkt(128'h11, 3'd1, 1'b0);
        send_pkt(128'h22, 3'd0, 1'b0);
        idle(3);
        chk("t2_count", 64'(obs.size()), 64'(2));
        if (obs.size() == 2) begin
            chk("t2_len1", 64'(obs[0]), 64'(36'hE00000011));
            chk("t2_len0", 64'(obs[1]), 64'(36'hE00000022));
        end

        // credit exhaustion on VC0
        do_reset();
        obs.delete();
        for (int i = 0; i < 11; i++) send_pkt(128'(i + 1), 3'd1, 1'b0);
        idle(3);
        chk("t3_sent10", 64'(obs.size()), 64'(10));
        chk("t3_stalled", 64'(ready), 64'(0));
        cred = 2'b01;
        idle(1);
        cred = '0;
        idle(3);
        chk("t3_sent11", 64'(obs.size()), 64'(11));
        chk("t3_ready", 64'(ready), 64'(1));

        // simultaneous return and fire with one credit left
        cred = 2'b01;
        idle(1);
        cred = '0;
        send_pkt({32'h0, 32'h0, 32'h52, 32'h51}, 3'd2, 1'b0);
        cred = 2'b01;
        idle(1);
        cred = '0;
        chk("t4_credit_hold", 64'(dut.credit_cnt[0]), 64'(1));
        idle(1);
        chk("t4_credit_used", 64'(dut.credit_cnt[0]), 64'(0));

        // overflow on a full counter
        do_reset();
        cred = 2'b01;
        idle(1);
        cred = '0;
        idle(3);
        chk("t5_err", 64'(err), 64'(1));
        chk("t5_credit0", 64'(dut.credit_cnt[0]), 64'(10));
        do_reset();
        chk("t5_err_cleared", 64'(err), 64'(0));

        // reset on the second flit of a 3-flit packet
        obs.delete();
        send_pkt({32'h0, 32'h73, 32'h72, 32'h71}, 3'd3, 1'b1);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t6_flit_zero", 64'(flit), 64'(0));
        chk("t6_credit0", 64'(dut.credit_cnt[0]), 64'(10));
        chk("t6_credit1", 64'(dut.credit_cnt[1]), 64'(10));
        chk("t6_partial", 64'(obs.size()), 64'(1));
        if (obs.size() == 1) chk("t6_head", 64'(obs[0]), 64'(36'hD00000071));
        obs.delete();
        send_pkt({32'h0, 32'h0, 32'h82, 32'h81}, 3'd2, 1'b0);
        idle(3);
        chk("t6_new_count", 64'(obs.size()), 64'(2));
        if (obs.size() == 2) begin
            chk("t6_new_head", 64'(obs[0]), 64'(36'hC00000081));
            chk("t6_new_tail", 64'(obs[1]), 64'(36'hA00000082));
        end

        // randomized traffic
        acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!valid || acc) begin
                valid = ($urandom_range(0, 9) < 6);
                pkt   = {$urandom, $urandom, $urandom, $urandom};
                len   = 3'($urandom_range(0, 7));
                vc    = 1'($urandom_range(0, 1));
            end
            cred[0] = ($urandom_range(0, 2) == 0);
            cred[1] = ($urandom_range(0, 2) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            step(acc);
        end
        rst = 1'b0; valid = 1'b0; cred = '0;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
